// File: rtl/vec_seq_checker.sv
// rtl/vec_seq_checker.sv - drives all 16 vectors into a 4-input DUT and checks f against a truth table
module vec_seq_checker #(
  parameter logic [15:0] TRUTH = 16'h0000,
  parameter int          DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  output logic [3:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_err_vec,
  output logic       err_seen
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [7:0] dwell_q, dwell_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] first_q, first_d;
  logic       err_seen_q, err_seen_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  assign mismatch = (f_in != TRUTH[vec_q]);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    dwell_d    = dwell_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    err_seen_d = err_seen_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = APPLY;
          vec_d      = 4'd0;
          dwell_d    = 8'd0;
          err_cnt_d  = 5'd0;
          first_d    = 4'd0;
          err_seen_d = 1'b0;
          pass_d     = 1'b0;
        end
      end
      APPLY: begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 8'd1;
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (!err_seen_q) begin
              first_d    = vec_q;
              err_seen_d = 1'b1;
            end
          end
          dwell_d = 8'd0;
          if (vec_q == 4'd15) begin
            // vec wraps to 0 so vec_out reads 0 during DONE; pass includes vector 15's result
            state_d = DONE;
            vec_d   = 4'd0;
            pass_d  = (err_cnt_d == 5'd0);
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= 4'd0;
      dwell_q    <= 8'd0;
      err_cnt_q  <= 5'd0;
      first_q    <= 4'd0;
      err_seen_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      dwell_q    <= dwell_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      err_seen_q <= err_seen_d;
      pass_q     <= pass_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = (state_q == APPLY);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vec = first_q;
  assign err_seen      = err_seen_q;

endmodule

// File: doc/vec_seq_checker.md
Name: vec_seq_checker

Overview:
- Synthesizable stimulus-and-response engine for 4-input combinational lab circuits.
- Drives the DUT inputs through all 16 input combinations {a,b,c,d} = 0..15 in ascending order.
- Holds each vector for a programmable dwell, samples the DUT output f, and compares it to a parameterised expected truth table.
- Reports mismatch count, first failing vector and pass/fail. It sits on the driving side of a DUT, so checking runs on hardware as well as in simulation.

Parameters:
- TRUTH, 16'h0000, expected truth table: expected f for input vector v is TRUTH[v], where v = {a,b,c,d} and a is the MSB.
- DWELL, 4, clock cycles each vector is held; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- f_in  input  1  DUT output under test.
- vec_out  output  4  applied vector {a,b,c,d}, driven to the DUT.
- busy  output  1  high while vectors are being applied.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the completed run had zero mismatches.
- err_cnt  output  5  mismatch count of the last run, range 0..16.
- first_err_vec  output  4  vector index of the first mismatch in the last run.
- err_seen  output  1  at least one mismatch in the last or current run.

Behaviour:
- Reset: rst is asynchronous and active-high; it acts immediately regardless of clk. It forces state=IDLE and dwell counter=0. All outputs go to 0: vec_out, busy, done, pass, err_cnt, first_err_vec, err_seen.
- FSM states: IDLE, APPLY, DONE.
- IDLE: vec_out=0, busy=0. Result outputs hold the values from the last run.
  - On an edge with start=1: go to APPLY; vec=0, dwell_cnt=0; clear err_cnt, err_seen, first_err_vec and pass; busy=1 from the next cycle.
- APPLY: vec_out=vec (registered), busy=1.
  - Each edge: if dwell_cnt != DWELL-1, then dwell_cnt++.
  - Else (sample edge): compare f_in against TRUTH[vec].
    - On mismatch: err_cnt++.
    - On mismatch with err_seen=0: first_err_vec=vec and err_seen=1.
    - Then dwell_cnt=0. If vec==15, go to DONE; else vec++.
- DONE: lasts exactly one cycle. done=1, busy=0, vec_out=0, pass=(err_cnt==0). Next edge goes to IDLE.
- Timing, with E0 = the edge that accepts start:
  - Vector k is driven from E0+k*DWELL to E0+(k+1)*DWELL.
  - Vector k is sampled at edge E0+(k+1)*DWELL-... more precisely, at the last edge of its dwell, E0+(k+1)*DWELL.
  - busy is high for exactly 16*DWELL cycles.
  - done is high for the single cycle after edge E0+16*DWELL.
  - err_cnt includes vector 15's result when done is high.
- f_in is sampled only on sample edges. The DUT must settle within DWELL cycles; with DWELL=1, f_in is sampled one cycle after vec_out changes.
- err_cnt cannot overflow: at most 16 mismatches fit in 5 bits, so no saturation logic.
- start is ignored in APPLY and DONE. If start is held high continuously, a new run begins on the first IDLE edge, i.e. 2 cycles after done rises.
- Reset asserted mid-run aborts the run: no done pulse, all outputs return to reset values.
- pass is meaningful only after done. It holds until the next start is accepted or reset.

Test Plan:
1. Reset: assert rst asynchronously between edges -> all outputs 0 immediately, state IDLE. Pulses of start while rst=1 have no effect.
2. Matching DUT: TRUTH=16'hA5C3, DWELL=4, f_in=TRUTH[vec_out] combinationally, start pulse at E0 -> vec_out steps 0..15, each held 4 cycles; busy high 64 cycles; done one cycle; pass=1, err_cnt=0, err_seen=0.
3. Stuck-at-0 DUT: TRUTH=16'hA5C3, f_in=0 -> err_cnt=8 (popcount of 16'hA5C3), first_err_vec=0, err_seen=1, pass=0.
4. Inverted DUT with DWELL=1: f_in=~TRUTH[vec_out] -> busy exactly 16 cycles, err_cnt=16, first_err_vec=0, pass=0.
5. Single fault at vector 13: f_in=TRUTH[vec_out] except flipped when vec_out=13 -> err_cnt=1, first_err_vec=13, pass=0. An immediate second run with a correct DUT -> result fields clear at start, ending with pass=1.
6. Protocol and abort:
   - start pulsed during APPLY at vector 5 -> no restart, sequence continues.
   - rst at vector 7 -> immediate reset values, no done.
   - start held high -> back-to-back runs with a 2-cycle gap after done.
